// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester side (req/data/last/ack/grant) and the UART TX
//   side (tx_valid/tx_data/tx_rdy/tx_done) plus status (busy/err) of the
//   round-robin UART transmit arbiter.
//   slave  : the arbiter (consumes requests and UART status, drives strobes)
//   master : the environment (requesters + UART transmitter)
//   data[n] holds requester n's byte; bit layout equals data[n*DATA_WIDTH +: DATA_WIDTH].
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]                 req;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data;
    logic [NUM_REQ-1:0]                 last;
    logic [NUM_REQ-1:0]                 ack;
    logic [NUM_REQ-1:0]                 grant;
    logic                               tx_valid;
    logic [DATA_WIDTH-1:0]              tx_data;
    logic                               tx_rdy;
    logic                               tx_done;
    logic                               busy;
    logic                               err;

    modport slave (
        input  req, data, last, tx_rdy, tx_done,
        output ack, grant, tx_valid, tx_data, busy, err
    );

    modport master (
        output req, data, last, tx_rdy, tx_done,
        input  ack, grant, tx_valid, tx_data, busy, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   One requester is granted at a time (round robin from rr_ptr); each of its
//   bytes is forwarded as a single-cycle tx_valid strobe with a matching ack,
//   and the next byte waits for the transmitter's tx_done pulse. Priority
//   rotates after a last byte, a MAX_BURST-byte burst, a dropped request or
//   a done timeout (which also pulses err).
// Ports
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   bus      : uart_tx_arbiter_if.slave
//              in : req, data, last, tx_rdy, tx_done
//              out: ack, grant, tx_valid, tx_data, busy, err (all registered)
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 16,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    uart_tx_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYC) + 1;

    localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [7:0]       BURST_END = 8'(MAX_BURST - 1);
    localparam logic [TMR_W-1:0] TMO_END   = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ARB, ISSUE, WAIT_DONE} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       g, g_nxt;
    logic [IDX_W-1:0]       rr_ptr, rr_nxt;
    logic [7:0]             burst_cnt, burst_nxt;
    logic [TMR_W-1:0]       timer, timer_nxt;
    logic                   last_f, last_nxt;

    logic [NUM_REQ-1:0]     ack_q, ack_nxt;
    logic [NUM_REQ-1:0]     grant_q, grant_nxt;
    logic                   tx_valid_q, tx_valid_nxt;
    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_nxt;
    logic                   busy_q, busy_nxt;
    logic                   err_q, err_nxt;

    // (base + off) mod NUM_REQ for base, off < NUM_REQ; works for
    // non-power-of-two NUM_REQ since the sum is below 2*NUM_REQ.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W-1:0] off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= NUM_REQ_W) s = s - NUM_REQ_W;
        return s[IDX_W-1:0];
    endfunction

    // Round-robin pick: first requester found scanning up from rr_ptr.
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && bus.req[wrap_add(rr_ptr, IDX_W'(i))]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_add(rr_ptr, IDX_W'(i));
            end
        end
    end

    logic rel_done;  // done on the frame's last byte or the burst's final byte
    logic tmo;

    assign rel_done = last_f || (burst_cnt == BURST_END);
    assign tmo      = (timer == TMO_END);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ARB;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:       if (pick_vld) state_nxt = ISSUE;
            ISSUE: begin
                if (!bus.req[g])     state_nxt = ARB;
                else if (bus.tx_rdy) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done takes precedence over a coincident timeout
                if (bus.tx_done)     state_nxt = rel_done ? ARB : ISSUE;
                else if (tmo)        state_nxt = ARB;
            end
            default:                 state_nxt = ARB;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        g_nxt        = g;
        rr_nxt       = rr_ptr;
        burst_nxt    = burst_cnt;
        timer_nxt    = timer;
        last_nxt     = last_f;
        ack_nxt      = '0;
        grant_nxt    = grant_q;
        tx_valid_nxt = 1'b0;
        tx_data_nxt  = tx_data_q;
        err_nxt      = 1'b0;
        case (state)
            ARB: begin
                grant_nxt = '0;
                if (pick_vld) begin
                    g_nxt     = pick_idx;
                    grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            ISSUE: begin
                if (!bus.req[g]) begin
                    // requester withdrew: rotate past it, no strobe
                    rr_nxt    = wrap_add(g, IDX_W'(1));
                    burst_nxt = '0;
                    grant_nxt = '0;
                end else if (bus.tx_rdy) begin
                    tx_valid_nxt = 1'b1;
                    tx_data_nxt  = bus.data[g];
                    ack_nxt[g]   = 1'b1;
                    last_nxt     = bus.last[g];
                    timer_nxt    = '0;
                end
            end
            WAIT_DONE: begin
                timer_nxt = timer + TMR_W'(1);
                if (bus.tx_done) begin
                    if (rel_done) begin
                        rr_nxt    = wrap_add(g, IDX_W'(1));
                        burst_nxt = '0;
                        grant_nxt = '0;
                    end else begin
                        burst_nxt = burst_cnt + 8'd1;
                    end
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    rr_nxt    = wrap_add(g, IDX_W'(1));
                    burst_nxt = '0;
                    grant_nxt = '0;
                end
            end
            default: grant_nxt = '0;
        endcase
        busy_nxt = (state_nxt != ARB);
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            g          <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            timer      <= '0;
            last_f     <= 1'b0;
            ack_q      <= '0;
            grant_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            g          <= g_nxt;
            rr_ptr     <= rr_nxt;
            burst_cnt  <= burst_nxt;
            timer      <= timer_nxt;
            last_f     <= last_nxt;
            ack_q      <= ack_nxt;
            grant_q    <= grant_nxt;
            tx_valid_q <= tx_valid_nxt;
            tx_data_q  <= tx_data_nxt;
            busy_q     <= busy_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.grant    = grant_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, MAX_BURST=4, TIMEOUT_CYC=64).
//   A UART model answers each strobe with tx_done DLY cycles later; an
//   auto-requester streams bytes {n, seq[3:0]}; manual drives cover the
//   corner cases. Outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int MB  = 4;
    localparam int TMO = 64;
    localparam int DLY = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYC(TMO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Manual / automatic requester and UART drive selection
    logic                  auto_m = 1'b0;
    logic [NR-1:0]         m_req = '0;
    logic [NR-1:0][DW-1:0] m_data = '0;
    logic [NR-1:0]         m_last = '0;
    logic [NR-1:0]         a_req;
    logic [NR-1:0][DW-1:0] a_data;
    logic [NR-1:0]         a_last;
    logic                  model_en = 1'b1;
    logic                  done_en = 1'b1;
    logic                  d_rdy = 1'b0;
    logic                  d_done = 1'b0;
    logic                  md_rdy = 1'b1;
    logic                  md_done = 1'b0;

    assign bus.req     = auto_m ? a_req : m_req;
    assign bus.data    = auto_m ? a_data : m_data;
    assign bus.last    = auto_m ? a_last : m_last;
    assign bus.tx_rdy  = model_en ? md_rdy : d_rdy;
    assign bus.tx_done = model_en ? md_done : d_done;

    // Auto requester: sends bytes until sent==tot; byte k is last when (k+1)%frame==0
    int sent  [NR] = '{default: 0};
    int tot   [NR] = '{default: 0};
    int frame [NR] = '{default: 1};

    always_comb begin
        a_req  = '0;
        a_data = '0;
        a_last = '0;
        for (int n = 0; n < NR; n++) begin
            a_req[n]  = sent[n] < tot[n];
            a_data[n] = 8'((n << 4) | (sent[n] & 15));
            a_last[n] = ((sent[n] + 1) % frame[n]) == 0;
        end
    end

    always @(negedge clk) begin
        if (auto_m)
            for (int n = 0; n < NR; n++)
                if (bus.ack[n]) sent[n] <= sent[n] + 1;
    end

    // UART model: busy DLY cycles after each strobe, then done (if enabled)
    int   cnt = 0;
    logic inflight = 1'b0;
    int   ovl = 0;

    always @(negedge clk) begin
        md_done <= 1'b0;
        if (model_en) begin
            if (bus.tx_valid) begin
                if (inflight) ovl <= ovl + 1;
                inflight <= 1'b1;
                cnt      <= DLY;
                md_rdy   <= 1'b0;
            end else if (inflight) begin
                if (cnt == 1) begin
                    inflight <= 1'b0;
                    md_rdy   <= 1'b1;
                    md_done  <= done_en;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Strobe log and ack/grant consistency monitor
    logic [DW-1:0] logd [$];
    logic [NR-1:0] logg [$];
    int            ackbad = 0;

    always @(negedge clk) begin
        if (bus.tx_valid) begin
            logd.push_back(bus.tx_data);
            logg.push_back(bus.grant);
        end
        if ((bus.ack != '0 || bus.tx_valid) && bus.ack != bus.grant) ackbad <= ackbad + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [DW-1:0] exp3_d [12] = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h23, 8'h24,
                                   8'h17, 8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C};
    logic [NR-1:0] exp3_g [12] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010};

    initial begin
        int base;
        int c;
        int nstb;

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_grant_in_reset", bus.grant, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_grant", bus.grant, 0);
        chk("rst_valid", bus.tx_valid, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_data", bus.tx_data, 0);

        // ---- 1: single byte from r0, 2-cycle latency, release
        m_req = 4'b0001; m_data = 32'h0000_0055; m_last = 4'b0001;
        @(negedge clk);
        chk("t1_grant", bus.grant, 4'b0001);
        chk("t1_no_early_strobe", bus.tx_valid, 0);
        chk("t1_busy", bus.busy, 1);
        @(negedge clk);
        chk("t1_strobe", bus.tx_valid, 1);
        chk("t1_data", bus.tx_data, 8'h55);
        chk("t1_ack", bus.ack, 4'b0001);
        m_req = '0;
        @(negedge clk);
        chk("t1_strobe_1cyc", bus.tx_valid, 0);
        chk("t1_ack_1cyc", bus.ack, 0);
        for (c = 0; c < 50 && bus.grant != '0; c++) @(negedge clk);
        chk("t1_release", bus.grant, 0);
        chk("t1_no_err", bus.err, 0);
        // rr_ptr should now be 1: with everyone requesting, r1 wins; drop it in ISSUE
        @(negedge clk);
        m_req = 4'b1111;
        @(negedge clk);
        chk("t1_rr_ptr1", bus.grant, 4'b0010);
        m_req = '0;
        @(negedge clk);
        chk("drop_grant", bus.grant, 0);
        chk("drop_no_strobe", bus.tx_valid, 0);
        chk("drop_no_ack", bus.ack, 0);
        chk("drop_busy", bus.busy, 0);

        // ---- 2: all four stream 3-byte frames, strict rotation
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = logd.size();
        for (int n = 0; n < NR; n++) begin
            frame[n] = 3;
            tot[n]   = 3;
        end
        auto_m = 1'b1;
        for (c = 0; c < 1000 && logd.size() < base + 12; c++) @(negedge clk);
        chk("t2_count", logd.size() - base, 12);
        for (int i = 0; i < 12 && base + i < logd.size(); i++) begin
            chk($sformatf("t2_data%0d", i), logd[base+i], ((i / 3) << 4) | (i % 3));
            chk($sformatf("t2_grant%0d", i), logg[base+i], 1 << (i / 3));
        end
        for (c = 0; c < 100 && bus.busy; c++) @(negedge clk);
        chk("t2_idle", bus.busy, 0);

        // ---- 3: burst limit 4, r1 streams 10 bytes, r2 sends 2
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = logd.size();
        frame[1] = 1000; frame[2] = 5;
        tot[1]   = 13;   tot[2]   = 5;
        for (c = 0; c < 1000 && logd.size() < base + 12; c++) @(negedge clk);
        chk("t3_count", logd.size() - base, 12);
        for (int i = 0; i < 12 && base + i < logd.size(); i++) begin
            chk($sformatf("t3_data%0d", i), logd[base+i], exp3_d[i]);
            chk($sformatf("t3_grant%0d", i), logg[base+i], exp3_g[i]);
        end
        for (c = 0; c < 100 && bus.busy; c++) @(negedge clk);
        chk("t3_idle", bus.busy, 0);
        chk("overlap", ovl, 0);
        chk("ack_vs_grant", ackbad, 0);

        // ---- 4: no done -> timeout after TMO cycles, next requester granted
        done_en = 1'b0;
        auto_m  = 1'b0;
        m_req = 4'b0011; m_data = 32'h0000_C1C0; m_last = 4'b0011;
        for (c = 0; c < 20 && !bus.tx_valid; c++) @(negedge clk);
        chk("t4_strobe", bus.tx_valid, 1);
        chk("t4_data", bus.tx_data, 8'hC0);
        chk("t4_grant", bus.grant, 4'b0001);
        m_req = 4'b0010;
        c = 0;
        while (!bus.err && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("t4_err_delay", c, TMO);
        chk("t4_err_release", bus.grant, 0);
        chk("t4_err_busy", bus.busy, 0);
        @(negedge clk);
        chk("t4_err_1cyc", bus.err, 0);
        chk("t4_next_grant", bus.grant, 4'b0010);
        @(negedge clk);
        chk("t4_next_strobe", bus.tx_valid, 1);
        chk("t4_next_data", bus.tx_data, 8'hC1);
        m_req = '0;

        // ---- 5: async reset mid-WAIT_DONE, then wait for tx_rdy
        repeat (2) @(negedge clk);
        model_en = 1'b0;
        d_rdy    = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_grant_now", bus.grant, 0);
        chk("t5_busy_now", bus.busy, 0);
        chk("t5_data_now", bus.tx_data, 0);
        chk("t5_valid_now", bus.tx_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_req = 4'b0001; m_data = 32'h0000_0077; m_last = 4'b0001;
        nstb = 0;
        repeat (5) begin
            @(negedge clk);
            nstb += int'(bus.tx_valid);
        end
        chk("t5_no_strobe_wo_rdy", nstb, 0);
        chk("t5_hold_grant", bus.grant, 4'b0001);
        d_rdy = 1'b1;
        @(negedge clk);
        chk("t5_strobe", bus.tx_valid, 1);
        chk("t5_data", bus.tx_data, 8'h77);
        m_req = '0;
        d_rdy = 1'b0;
        repeat (3) @(negedge clk);
        d_done = 1'b1;
        @(negedge clk);
        d_done = 1'b0;
        chk("t5_release", bus.grant, 0);
        chk("t5_no_err", bus.err, 0);

        // ---- 6: stray done in ARB, drop while rdy=0, done+timeout coincident
        d_done = 1'b1;
        @(negedge clk);
        d_done = 1'b0;
        chk("t6_stray_done_busy", bus.busy, 0);
        m_req = 4'b0100; m_last = 4'b0100; m_data = 32'h00A2_0000;
        @(negedge clk);
        chk("t6_grant2", bus.grant, 4'b0100);
        nstb = 0;
        repeat (2) begin
            @(negedge clk);
            nstb += int'(bus.tx_valid);
        end
        chk("t6_no_strobe", nstb, 0);
        m_req = '0;
        @(negedge clk);
        chk("t6_drop_grant", bus.grant, 0);
        chk("t6_drop_ack", bus.ack, 0);
        chk("t6_drop_valid", bus.tx_valid, 0);
        m_req = 4'b1001; m_last = 4'b1001; m_data = 32'hD300_00B0;
        @(negedge clk);
        chk("t6_rr_ptr3", bus.grant, 4'b1000);
        d_rdy = 1'b1;
        @(negedge clk);
        chk("t6_strobe", bus.tx_valid, 1);
        chk("t6_data", bus.tx_data, 8'hD3);
        m_req = '0;
        d_rdy = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        d_done = 1'b1;
        @(negedge clk);
        d_done = 1'b0;
        chk("t6_done_wins_err", bus.err, 0);
        chk("t6_done_release", bus.grant, 0);
        @(negedge clk);
        chk("t6_no_late_err", bus.err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
